// File: rtl/apb_ssd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : apb_ssd_ctrl
//  Purpose  : APB3 slave that owns six hex digits for the board's seven-
//             segment displays, with a prescaler/event timer used for digit
//             blinking and an autonomous 24-bit hex count-up mode.
//  Ports    : clk, reset           - clock, synchronous active-high reset
//             S_PADDR..S_PREADY    - APB3 slave port (zero wait states)
//             ssd_chars[23:0]      - digit i code at [4i+3:4i]
//             ssd_blank[5:0]       - 1 = digit i is blanked
//  Revision : 1.0 - initial release
// ============================================================================
module apb_ssd_ctrl #(
  parameter logic [15:0] PRESCALE_RST = 16'd49999,
  parameter logic [7:0]  RATE_RST     = 8'd249
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] S_PADDR,
  input  logic        S_PWRITE,
  input  logic        S_PSELx,
  input  logic        S_PENABLE,
  input  logic [15:0] S_PWDATA,
  output logic [15:0] S_PRDATA,
  output logic        S_PREADY,
  output logic [23:0] ssd_chars,
  output logic [5:0]  ssd_blank
);

  localparam logic [2:0] c_idx_dig_lo   = 3'd0;
  localparam logic [2:0] c_idx_dig_hi   = 3'd1;
  localparam logic [2:0] c_idx_ctrl     = 3'd2;
  localparam logic [2:0] c_idx_prescale = 3'd3;
  localparam logic [2:0] c_idx_rate     = 3'd4;
  localparam logic [2:0] c_idx_status   = 3'd5;
  localparam logic [7:0] c_ctrl_rst     = 8'h3F;

  // Registers
  logic [23:0] digits_q,   digits_d;
  logic [7:0]  ctrl_q,     ctrl_d;
  logic [15:0] prescale_q, prescale_d;
  logic [7:0]  rate_q,     rate_d;
  logic [15:0] pc_q,       pc_d;
  logic [7:0]  rc_q,       rc_d;
  logic        phase_q,    phase_d;
  logic [7:0]  evcnt_q,    evcnt_d;
  logic [5:0]  blank_q,    blank_d;

  // APB decode
  logic       w_access;
  logic       w_wr;
  logic [2:0] w_idx;
  logic       w_cfg_wr;
  logic       w_tick;
  logic       w_event;
  logic       w_unused_addr;

  assign w_access      = S_PSELx & S_PENABLE;
  assign w_wr          = w_access & S_PWRITE;
  assign w_idx         = S_PADDR[2:0];
  assign w_unused_addr = ^S_PADDR[15:3];
  assign S_PREADY      = w_access;

  // A timing-register write restarts the timebase; the restart edge itself
  // must not produce a tick, so the write masks the terminal-count compare.
  assign w_cfg_wr = w_wr & ((w_idx == c_idx_prescale) | (w_idx == c_idx_rate));
  assign w_tick   = (pc_q == prescale_q) & ~w_cfg_wr;
  assign w_event  = w_tick & (rc_q == rate_q);

  always_comb begin
    digits_d   = digits_q;
    ctrl_d     = ctrl_q;
    prescale_d = prescale_q;
    rate_d     = rate_q;
    pc_d       = pc_q;
    rc_d       = rc_q;
    phase_d    = phase_q;
    evcnt_d    = evcnt_q;

    // Timebase
    if (w_cfg_wr) begin
      pc_d = 16'd0;
      rc_d = 8'd0;
    end else begin
      pc_d = w_tick ? 16'd0 : pc_q + 16'd1;
      if (w_tick) begin
        rc_d = w_event ? 8'd0 : rc_q + 8'd1;
      end
    end

    // Event consequences
    if (w_event) begin
      phase_d = ~phase_q;
      evcnt_d = evcnt_q + 8'd1;
      if (ctrl_q[7]) begin
        digits_d = digits_q + 24'd1;
      end
    end

    // Register writes; a digit write overrides only its own half, so the
    // other half keeps the incremented value (carry from the old value).
    if (w_wr) begin
      case (w_idx)
        c_idx_dig_lo:   digits_d[15:0]  = S_PWDATA;
        c_idx_dig_hi:   digits_d[23:16] = S_PWDATA[7:0];
        c_idx_ctrl:     ctrl_d          = S_PWDATA[7:0];
        c_idx_prescale: prescale_d      = S_PWDATA;
        c_idx_rate:     rate_d          = S_PWDATA[7:0];
        default:        ;
      endcase
    end

    // Blank mask is computed from registered state, hence one cycle of lag
    blank_d = ~ctrl_q[5:0] | {6{ctrl_q[6] & phase_q}};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      digits_q   <= 24'h000000;
      ctrl_q     <= c_ctrl_rst;
      prescale_q <= PRESCALE_RST;
      rate_q     <= RATE_RST;
      pc_q       <= 16'd0;
      rc_q       <= 8'd0;
      phase_q    <= 1'b0;
      evcnt_q    <= 8'd0;
      blank_q    <= 6'h00;
    end else begin
      digits_q   <= digits_d;
      ctrl_q     <= ctrl_d;
      prescale_q <= prescale_d;
      rate_q     <= rate_d;
      pc_q       <= pc_d;
      rc_q       <= rc_d;
      phase_q    <= phase_d;
      evcnt_q    <= evcnt_d;
      blank_q    <= blank_d;
    end
  end

  // Read mux
  always_comb begin
    S_PRDATA = 16'h0000;
    if (S_PSELx) begin
      case (w_idx)
        c_idx_dig_lo:   S_PRDATA = digits_q[15:0];
        c_idx_dig_hi:   S_PRDATA = {8'h00, digits_q[23:16]};
        c_idx_ctrl:     S_PRDATA = {8'h00, ctrl_q};
        c_idx_prescale: S_PRDATA = prescale_q;
        c_idx_rate:     S_PRDATA = {8'h00, rate_q};
        c_idx_status:   S_PRDATA = {evcnt_q, 7'd0, phase_q};
        default:        S_PRDATA = 16'h0000;
      endcase
    end
  end

  assign ssd_chars = digits_q;
  assign ssd_blank = blank_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_ssd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apb_ssd_ctrl
//  Purpose  : Self-checking bench for apb_ssd_ctrl: directed scenarios then
//             randomized APB traffic against a cycle-count reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_apb_ssd_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] paddr = 16'h0;
  logic        pwrite = 1'b0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic [15:0] pwdata = 16'h0;
  logic [15:0] prdata;
  logic        pready;
  logic [23:0] chars;
  logic [5:0]  blank;

  int checks = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  apb_ssd_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .S_PADDR   (paddr),
    .S_PWRITE  (pwrite),
    .S_PSELx   (psel),
    .S_PENABLE (penable),
    .S_PWDATA  (pwdata),
    .S_PRDATA  (prdata),
    .S_PREADY  (pready),
    .ssd_chars (chars),
    .ssd_blank (blank)
  );

  always #5 clk = ~clk;

  // Reference model: events happen every (PRESCALE+1)*(RATE+1) edges counted
  // from the last timebase restart (reset or PRESCALE/RATE write).
  logic [23:0] m_digits;
  logic [7:0]  m_ctrl;
  logic [15:0] m_pre;
  logic [7:0]  m_rate;
  longint      m_n;
  logic        m_phase;
  logic [7:0]  m_evc;
  logic [5:0]  m_blank;

  always @(posedge clk) begin : ref_model
    logic        wr;
    logic [2:0]  a;
    logic        clr;
    logic        ev;
    logic [23:0] nd;
    longint      n;
    longint      period;
    if (reset) begin
      m_digits <= 24'h0;
      m_ctrl   <= 8'h3F;
      m_pre    <= 16'd49999;
      m_rate   <= 8'd249;
      m_n      <= 0;
      m_phase  <= 1'b0;
      m_evc    <= 8'd0;
      m_blank  <= 6'h00;
    end else begin
      wr     = psel & penable & pwrite;
      a      = paddr[2:0];
      clr    = wr && (a == 3'd3 || a == 3'd4);
      period = (longint'(m_pre) + 1) * (longint'(m_rate) + 1);
      n      = clr ? 0 : m_n + 1;
      ev     = !clr && ((n % period) == 0);
      nd     = m_digits;
      if (ev && m_ctrl[7]) nd = nd + 24'd1;
      if (wr && a == 3'd0) nd[15:0] = pwdata;
      if (wr && a == 3'd1) nd[23:16] = pwdata[7:0];
      m_digits <= nd;
      m_n      <= n;
      if (ev) begin
        m_phase <= ~m_phase;
        m_evc   <= m_evc + 8'd1;
      end
      m_blank <= ~m_ctrl[5:0] | {6{m_ctrl[6] & m_phase}};
      if (wr && a == 3'd2) m_ctrl <= pwdata[7:0];
      if (wr && a == 3'd3) m_pre  <= pwdata;
      if (wr && a == 3'd4) m_rate <= pwdata[7:0];
    end
  end

  function automatic logic [15:0] m_read(input logic [2:0] a);
    case (a)
      3'd0:    return m_digits[15:0];
      3'd1:    return {8'h00, m_digits[23:16]};
      3'd2:    return {8'h00, m_ctrl};
      3'd3:    return m_pre;
      3'd4:    return {8'h00, m_rate};
      3'd5:    return {m_evc, 7'd0, m_phase};
      default: return 16'h0000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (chk_en) begin
      chk("ssd_chars", {8'h0, chars}, {8'h0, m_digits});
      chk("ssd_blank", {26'h0, blank}, {26'h0, m_blank});
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic apb_write(input logic [15:0] addr, input logic [15:0] data);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data;
    #1;
    chk("pready_setup_wr", {31'h0, pready}, 32'h0);
    step();
    penable = 1'b1;
    #1;
    chk("pready_access_wr", {31'h0, pready}, 32'h1);
    step();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [15:0] addr, output logic [15:0] data);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr;
    #1;
    chk("pready_setup_rd", {31'h0, pready}, 32'h0);
    step();
    penable = 1'b1;
    #1;
    chk("pready_access_rd", {31'h0, pready}, 32'h1);
    data = prdata;
    chk("prdata", {16'h0, prdata}, {16'h0, m_read(addr[2:0])});
    step();
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic check_reset_regs();
    logic [15:0] tbl [8];
    logic [15:0] rd;
    tbl = '{16'h0000, 16'h0000, 16'h003F, 16'hC34F, 16'h00F9, 16'h0000, 16'h0000, 16'h0000};
    for (int i = 0; i < 8; i++) begin
      apb_read(16'(i), rd);
      chk("reset_reg", {16'h0, rd}, {16'h0, tbl[i]});
    end
    chk("reset_blank", {26'h0, blank}, 32'h0);
    chk("reset_chars", {8'h0, chars}, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd;
    logic [15:0] s1;
    logic [15:0] s2;
    logic [2:0]  idx;
    logic [15:0] d;
    int          op;

    // Reset
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("rst_chars_held", {8'h0, chars}, 32'h0);
    chk("rst_prdata_idle", {16'h0, prdata}, 32'h0);
    reset = 1'b0;
    check_reset_regs();

    // Static digits
    apb_write(16'h0000, 16'hBEEF);
    apb_write(16'h0001, 16'h12AD);
    chk("chars_adbeef", {8'h0, chars}, 32'h00ADBEEF);
    apb_read(16'h0001, rd);
    chk("dig_hi_read", {16'h0, rd}, 32'h000000AD);

    // Blinking: PRESCALE=1, RATE=2 -> event every 6 edges after RATE write
    apb_write(16'h0003, 16'h0001);
    apb_write(16'h0004, 16'h0002);
    apb_write(16'h0002, 16'h007F);
    cyc(3);
    chk("blink_off_before", {26'h0, blank}, 32'h00);
    cyc(2);
    chk("blink_on", {26'h0, blank}, 32'h3F);
    cyc(6);
    chk("blink_off_again", {26'h0, blank}, 32'h00);
    apb_read(16'h0005, s1);
    cyc(4);
    apb_read(16'h0005, s2);
    chk("evcnt_per_6", {24'h0, 8'(s2[15:8] - s1[15:8])}, 32'h1);
    chk("phase_flip", {31'h0, s2[0] ^ s1[0]}, 32'h1);

    // Count wrap
    apb_write(16'h0003, 16'h0000);
    apb_write(16'h0004, 16'h0000);
    apb_write(16'h0000, 16'hFFFF);
    apb_write(16'h0001, 16'h00FF);
    apb_write(16'h0002, 16'h0080);
    chk("pre_wrap", {8'h0, chars}, 32'h00FFFFFF);
    step();
    chk("wrap_zero", {8'h0, chars}, 32'h0);
    step();
    chk("wrap_one", {8'h0, chars}, 32'h1);

    // Write colliding with an increment carrying into the high half
    apb_write(16'h0002, 16'h0000);
    apb_write(16'h0001, 16'h0000);
    apb_write(16'h0000, 16'hFFFE);
    apb_write(16'h0002, 16'h0080);
    apb_write(16'h0000, 16'h1234);
    chk("write_wins_carry", {8'h0, chars}, 32'h00011234);

    // Reset mid-blink during a CTRL access phase
    apb_write(16'h0002, 16'h007F);
    cyc(3);
    psel = 1'b1; pwrite = 1'b1; paddr = 16'h0002; pwdata = 16'h0015; penable = 1'b0;
    step();
    penable = 1'b1;
    reset = 1'b1;
    step();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    reset = 1'b0;
    check_reset_regs();

    // Randomized traffic
    apb_write(16'h0003, 16'($urandom_range(0, 3)));
    apb_write(16'h0004, 16'($urandom_range(0, 3)));
    for (int k = 0; k < 200; k++) begin
      op  = int'($urandom_range(0, 9));
      idx = 3'($urandom_range(0, 7));
      d   = 16'($urandom);
      if (op <= 3) begin
        if (idx == 3'd3 || idx == 3'd4) d = 16'($urandom_range(0, 3));
        apb_write({13'($urandom), idx}, d);
      end else if (op <= 6) begin
        apb_read({13'($urandom), idx}, rd);
      end else if (op <= 8) begin
        cyc(int'($urandom_range(1, 4)));
      end else if (k % 5 == 0) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
        apb_write(16'h0003, 16'($urandom_range(0, 3)));
        apb_write(16'h0004, 16'($urandom_range(0, 3)));
      end else begin
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
